// File: rtl/nibble_sum_accumulator.sv
`timescale 1ns/1ps
// nibble_sum_accumulator
// Accumulates a stream of IN_W-bit samples over windows of WINDOW samples and
// emits per-window {saturated sum, max sample, saturation flag}. A single
// output register plus one pending slot let the block stall the producer
// instead of dropping a completed window.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   in_valid   producer has a sample on in_data
//   in_data    sample value (unsigned, IN_W bits)
//   in_ready   block accepts a sample this cycle (combinational, low during clear)
//   clear      synchronous flush of partial window, pending slot and output register
//   out_valid  out_sum/out_max/out_sat hold a completed window
//   out_ready  consumer takes the result this cycle
//   out_sum    saturated window sum (ACC_W bits)
//   out_max    largest sample of the window
//   out_sat    window sum hit 2^ACC_W-1
module nibble_sum_accumulator #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned ACC_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [IN_W-1:0]  out_max,
    output logic             out_sat
);

    localparam int unsigned      CNT_W   = $clog2(WINDOW + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [IN_W-1:0]    max_q;
    logic               sat_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ACC_W-1:0]   pend_sum_q;
    logic [IN_W-1:0]    pend_max_q;
    logic               pend_sat_q;

    logic               out_valid_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic [IN_W-1:0]    out_max_q;
    logic               out_sat_q;

    // Window state after absorbing the current sample
    logic [ACC_W:0]     sum_wide;
    logic               clamp;
    logic [ACC_W-1:0]   acc_d;
    logic [IN_W-1:0]    max_d;
    logic               sat_d;

    logic               accept;
    logic               last;
    logic               out_take;
    logic               out_free;

    // Saturating add: the extra top bit of the widened sum flags overflow
    always_comb begin
        sum_wide = {1'b0, acc_q} + (ACC_W+1)'(in_data);
        clamp    = sum_wide[ACC_W];
        acc_d    = clamp ? ACC_MAX : sum_wide[ACC_W-1:0];
        sat_d    = sat_q | clamp;
        max_d    = (in_data > max_q) ? in_data : max_q;
    end

    assign in_ready = (state_q == ST_ACCUM) && !clear;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == CNT_W'(WINDOW - 1));
    assign out_take = out_valid_q && out_ready;
    // Output register can take a new result at this edge
    assign out_free = !out_valid_q || out_ready;

    // Window FSM, pending slot and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            pend_sum_q  <= '0;
            pend_max_q  <= '0;
            pend_sat_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            pend_sum_q  <= '0;
            pend_max_q  <= '0;
            pend_sat_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept && last) begin
                        // Window complete: restart accumulation immediately
                        acc_q <= '0;
                        max_q <= '0;
                        sat_q <= 1'b0;
                        cnt_q <= '0;
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_sum_q   <= acc_d;
                            out_max_q   <= max_d;
                            out_sat_q   <= sat_d;
                        end else begin
                            pend_sum_q <= acc_d;
                            pend_max_q <= max_d;
                            pend_sat_q <= sat_d;
                            state_q    <= ST_HOLD;
                        end
                    end else begin
                        if (accept) begin
                            acc_q <= acc_d;
                            max_q <= max_d;
                            sat_q <= sat_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (out_take) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Output register is necessarily full here
                    if (out_take) begin
                        out_sum_q <= pend_sum_q;
                        out_max_q <= pend_max_q;
                        out_sat_q <= pend_sat_q;
                        state_q   <= ST_ACCUM;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_max   = out_max_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
`timescale 1ns/1ps
// Scoreboard bench: two instances (ACC_W=12 and ACC_W=6) share all inputs,
// so handshake timing is identical and one expected entry covers both.
module tb_nibble_sum_accumulator;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clear;
    logic        out_ready;

    logic        in_ready,  in_ready6;
    logic        out_valid, out_valid6;
    logic [11:0] out_sum;
    logic [5:0]  out_sum6;
    logic [3:0]  out_max,   out_max6;
    logic        out_sat,   out_sat6;

    nibble_sum_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_max(out_max),
        .out_sat(out_sat)
    );

    nibble_sum_accumulator #(.ACC_W(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready6), .clear(clear), .out_valid(out_valid6),
        .out_ready(out_ready), .out_sum(out_sum6), .out_max(out_max6),
        .out_sat(out_sat6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int max;
        int sat;
        int sum6;
        int sat6;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int s, input int m, input int sa, input int s6, input int sa6);
        exp_t e;
        e.sum = s; e.max = m; e.sat = sa; e.sum6 = s6; e.sat6 = sa6;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted; cyc = cycles spent
    task automatic send(input logic [3:0] v, output int cyc);
        logic ok;
        in_valid = 1'b1;
        in_data  = v;
        cyc      = 0;
        do begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 200);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_n(input logic [3:0] v, input int n, output int total);
        int c;
        total = 0;
        for (int i = 0; i < n; i++) begin
            send(v, c);
            total += c;
        end
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        step();
        chk("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid && ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !clear && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum %0d expected no result", out_sum);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_sum",    out_sum,    e.sum);
                    chk("out_max",    out_max,    e.max);
                    chk("out_sat",    out_sat,    e.sat);
                    chk("out_valid6", out_valid6, 1);
                    chk("out_sum6",   out_sum6,   e.sum6);
                    chk("out_max6",   out_max6,   e.max);
                    chk("out_sat6",   out_sat6,   e.sat6);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_sum"},   out_sum,   0);
        chk({tag, "_out_max"},   out_max,   0);
        chk({tag, "_out_sat"},   out_sat,   0);
        chk({tag, "_out_sum6"},  out_sum6,  0);
    endtask

    initial begin
        int total;
        int c;
        logic [3:0] win [8];
        int s, s6, m, sa6;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        clear     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("reset_in_ready", in_ready, 1);

        // Ramp 1..8 then eight 3s, out_ready high, no stalls expected
        out_ready = 1'b1;
        push_exp(36, 8, 0, 36, 0);
        push_exp(24, 3, 0, 24, 0);
        total = 0;
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), c);
            total += c;
        end
        send_n(4'd3, 8, c);
        total += c;
        chk("ramp_no_gap_cycles", total, 16);
        drain();

        // Back-pressure: 16 x 15 with out_ready low fills output and pending
        out_ready = 1'b0;
        push_exp(120, 15, 0, 63, 1);
        push_exp(120, 15, 0, 63, 1);
        send_n(4'd15, 16, c);
        chk("hold_in_ready",  in_ready,  0);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_sum",   out_sum,   120);
        repeat (3) step();
        chk("hold_stable_sum", out_sum,  120);
        chk("hold_still_stall", in_ready, 0);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("hold_exit_out_valid", out_valid, 0);
        chk("hold_exit_in_ready",  in_ready,  1);
        push_exp(120, 15, 0, 63, 1);
        send_n(4'd15, 8, c);
        drain();

        // Saturation on the narrow instance, then a clean window
        push_exp(120, 15, 0, 63, 1);
        push_exp(8, 1, 0, 8, 0);
        send_n(4'd15, 8, c);
        send_n(4'd1, 8, c);
        drain();

        // Clear mid-window drops the partial sum
        send_n(4'd9, 5, c);
        in_valid = 1'b1;
        in_data  = 4'd9;
        clear    = 1'b1;
        @(negedge clk);
        chk("clear_in_ready",  in_ready,  0);
        chk("clear_in_ready6", in_ready6, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        push_exp(16, 2, 0, 16, 0);
        send_n(4'd2, 8, c);
        drain();

        // Async reset mid-window
        send_n(4'd7, 3, c);
        #3;
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("rst_mid_in_ready", in_ready, 1);

        // Async reset while in HOLD drops both stored results
        out_ready = 1'b0;
        push_exp(120, 15, 0, 63, 1);
        push_exp(120, 15, 0, 63, 1);
        send_n(4'd15, 16, c);
        chk("rst_hold_in_ready_pre", in_ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_hold");
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("rst_hold_in_ready", in_ready, 1);
        out_ready = 1'b1;
        push_exp(32, 4, 0, 32, 0);
        send_n(4'd4, 8, c);
        drain();

        // Random bubbles and random out_ready, 125 windows = 1000 samples
        rand_ready = 1'b1;
        for (int w = 0; w < 125; w++) begin
            s = 0; s6 = 0; m = 0; sa6 = 0;
            for (int i = 0; i < 8; i++) begin
                win[i] = 4'($urandom_range(0, 15));
                s  += int'(win[i]);
                s6 += int'(win[i]);
                if (s6 > 63) begin
                    s6  = 63;
                    sa6 = 1;
                end
                if (int'(win[i]) > m) m = int'(win[i]);
            end
            push_exp(s, m, 0, s6, sa6);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        out_ready = 1'($urandom_range(0, 1));
                        step();
                    end
                end
                send(win[i], c);
            end
        end
        rand_ready = 1'b0;
        drain();

        chk("final_sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
